// File: rtl/rv32i_except_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv32i_except_ctrl_if
//   Signal bundle between the exception sources / pipeline status and the
//   exception controller.
//
//   Handshake semantics (the only handshake in this bundle):
//     i_except_vld[k] is a level request from source k. A request is accepted
//     only when the controller captures it (IDLE, or DONE together with
//     i_ack). A request seen at any other time is not queued; it only sets
//     o_dropped. o_done is the controller's "valid" for the completed
//     exception and i_ack is the trap unit's "ready": the exception is handed
//     off on the rising clk edge where o_done=1 and i_ack=1. i_ack while
//     o_done=0 has no effect.
//
//   Modports:
//     slave  : the controller (consumes i_*, drives o_*)
//     master : the environment (drives i_*, observes o_*)
//
//   Signals:
//     i_except_vld        per-source exception request (level)
//     i_except_cause      per-source cause, source k at [k*CAUSE_W +: CAUSE_W]
//     i_except_pc         per-source faulting PC, source k at [k*32 +: 32]
//     i_rf_except_in_prog register-file recovery busy
//     i_rob_flush         ROB flush busy
//     i_pu_rdy            per-PU ready
//     i_pu_vld            per-PU output valid
//     i_ack               trap unit accepted the completed exception
//     o_in_prog           exception handling active (gates decode valid)
//     o_flush             single-cycle pipeline flush pulse
//     o_done              drain complete, held until acknowledged
//     o_src_id            winning source index
//     o_cause             latched cause
//     o_epc               latched PC
//     o_timeout           sticky: drain ended by timeout
//     o_dropped           sticky: request seen while busy
//     o_state             current FSM state, for debug visibility
// ---------------------------------------------------------------------------
interface rv32i_except_ctrl_if #(
  parameter int NUM_SRCS = 4,
  parameter int NUM_PUS  = 4,
  parameter int CAUSE_W  = 5
);
  localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  logic [NUM_SRCS-1:0]         i_except_vld;
  logic [NUM_SRCS*CAUSE_W-1:0] i_except_cause;
  logic [NUM_SRCS*32-1:0]      i_except_pc;
  logic                        i_rf_except_in_prog;
  logic                        i_rob_flush;
  logic [NUM_PUS-1:0]          i_pu_rdy;
  logic [NUM_PUS-1:0]          i_pu_vld;
  logic                        i_ack;

  logic                        o_in_prog;
  logic                        o_flush;
  logic                        o_done;
  logic [SRC_W-1:0]            o_src_id;
  logic [CAUSE_W-1:0]          o_cause;
  logic [31:0]                 o_epc;
  logic                        o_timeout;
  logic                        o_dropped;
  logic [1:0]                  o_state;

  modport slave (
    input  i_except_vld, i_except_cause, i_except_pc,
    input  i_rf_except_in_prog, i_rob_flush, i_pu_rdy, i_pu_vld, i_ack,
    output o_in_prog, o_flush, o_done, o_src_id, o_cause, o_epc,
    output o_timeout, o_dropped, o_state
  );

  modport master (
    output i_except_vld, i_except_cause, i_except_pc,
    output i_rf_except_in_prog, i_rob_flush, i_pu_rdy, i_pu_vld, i_ack,
    input  o_in_prog, o_flush, o_done, o_src_id, o_cause, o_epc,
    input  o_timeout, o_dropped, o_state
  );
endinterface

// File: rtl/rv32i_except_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_except_ctrl
//   Precise-exception sequencer for an RV32I core. It picks the
//   lowest-index requesting source, latches its id/cause/PC, issues a
//   one-cycle pipeline flush, waits for the machine to go quiet (no PU
//   output valid, all PUs ready, no RF recovery, no ROB flush) or for a
//   drain timeout, then presents o_done until the trap unit acknowledges.
//
//   Ports:
//     clk  sole clock, rising edge
//     rst  asynchronous active-high reset
//     bus  rv32i_except_ctrl_if.slave (requests, pipeline status, results)
//
//   Parameters:
//     NUM_SRCS  number of exception sources (1..8)
//     NUM_PUS   number of processing units monitored for drain
//     CAUSE_W   cause code width
//     TMO_W     drain-timeout counter width; timeout at 2**TMO_W-1 cycles
// ---------------------------------------------------------------------------
module rv32i_except_ctrl #(
  parameter int NUM_SRCS = 4,
  parameter int NUM_PUS  = 4,
  parameter int CAUSE_W  = 5,
  parameter int TMO_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_except_ctrl_if.slave bus
);

  localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Terminal count: the counter stops here and never wraps.
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

  logic [1:0]         state;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [SRC_W-1:0]   src_id_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [31:0]        epc_q;
  logic               timeout_q;
  logic               dropped_q;

  logic               quiet;
  logic               any_req;
  logic               capture;
  logic               busy_req;
  logic               tmo_hit;
  logic [SRC_W-1:0]   win_id;
  logic [CAUSE_W-1:0] win_cause;
  logic [31:0]        win_pc;

  // ------------------------------------------------------------------------
  // Pipeline quiet: nothing left in flight that could still retire.
  // ------------------------------------------------------------------------
  assign quiet = ~|bus.i_pu_vld & (&bus.i_pu_rdy) &
                 ~bus.i_rf_except_in_prog & ~bus.i_rob_flush;

  assign any_req = |bus.i_except_vld;

  // ------------------------------------------------------------------------
  // Lowest-index priority select. Scanning from the top down lets the last
  // hit (the lowest asserted index) win.
  // ------------------------------------------------------------------------
  always_comb begin
    win_id    = '0;
    win_cause = '0;
    win_pc    = '0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      if (bus.i_except_vld[k]) begin
        win_id    = SRC_W'(k);
        win_cause = bus.i_except_cause[k*CAUSE_W +: CAUSE_W];
        win_pc    = bus.i_except_pc[k*32 +: 32];
      end
    end
  end

  // A new exception is accepted from IDLE, or straight out of DONE on the
  // acknowledge cycle so back-to-back exceptions skip the IDLE bubble.
  assign capture = any_req &
                   ((state == ST_IDLE) | ((state == ST_DONE) & bus.i_ack));

  // Requests arriving while the controller owns an exception are lost.
  assign busy_req = any_req &
                    ((state == ST_FLUSH) | (state == ST_DRAIN) |
                     ((state == ST_DONE) & ~bus.i_ack));

  // Last counted cycle of an unquiet drain.
  assign tmo_hit = (state == ST_DRAIN) & ~quiet & (tmo_cnt == TMO_LAST);

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (quiet || tmo_hit) state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.i_ack) state <= any_req ? ST_FLUSH : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Drain timeout counter: cleared during FLUSH so every drain starts from
  // zero, counts unquiet DRAIN cycles, holds at the terminal value.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_FLUSH) begin
      tmo_cnt <= '0;
    end else if ((state == ST_DRAIN) && !quiet && (tmo_cnt != TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Latched exception fields: written only on capture, so they stay stable
  // through FLUSH/DRAIN/DONE and any dropped request.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_id_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else if (capture) begin
      src_id_q <= win_id;
      cause_q  <= win_cause;
      epc_q    <= win_pc;
    end
  end

  // ------------------------------------------------------------------------
  // Sticky status. Both belong to the exception being handled, so a new
  // capture starts them afresh; otherwise they only ever set.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
      dropped_q <= 1'b0;
    end else if (capture) begin
      timeout_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      if (tmo_hit)  timeout_q <= 1'b1;
      if (busy_req) dropped_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs. Status flags decode straight from the state register, so they
  // change only on a clock edge (or immediately on reset).
  // ------------------------------------------------------------------------
  assign bus.o_in_prog = (state != ST_IDLE);
  assign bus.o_flush   = (state == ST_FLUSH);
  assign bus.o_done    = (state == ST_DONE);
  assign bus.o_src_id  = src_id_q;
  assign bus.o_cause   = cause_q;
  assign bus.o_epc     = epc_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_dropped = dropped_q;
  assign bus.o_state   = state;

endmodule

// File: tb/tb_rv32i_except_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_except_ctrl
//   Randomized and directed stimulus for rv32i_except_ctrl. Expected
//   completion records {src_id, cause, epc, timeout, dropped} are queued when
//   an exception is issued; a monitor pops one on every rising o_done.
// ---------------------------------------------------------------------------
module tb_rv32i_except_ctrl;

  localparam int NUM_SRCS = 4;
  localparam int NUM_PUS  = 4;
  localparam int CAUSE_W  = 5;
  localparam int TMO_W    = 4;
  localparam int SRC_W    = 2;
  localparam int TMO_LIM  = (1 << TMO_W) - 1;
  localparam int EXP_W    = SRC_W + CAUSE_W + 32 + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_except_ctrl_if #(
    .NUM_SRCS(NUM_SRCS), .NUM_PUS(NUM_PUS), .CAUSE_W(CAUSE_W)
  ) bus ();

  rv32i_except_ctrl #(
    .NUM_SRCS(NUM_SRCS), .NUM_PUS(NUM_PUS), .CAUSE_W(CAUSE_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               tests = 0;
  int               fails = 0;
  logic             prev_done = 1'b0;

  logic [SRC_W-1:0]   last_id;
  logic [CAUSE_W-1:0] last_cause;
  logic [31:0]        last_epc;
  logic               last_to;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (bus.o_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          check("done_record",
                {bus.o_src_id, bus.o_cause, bus.o_epc, bus.o_timeout, bus.o_dropped},
                e);
        end
      end
      prev_done = bus.o_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_quiet(input bit q);
    bus.i_pu_vld            = '0;
    bus.i_pu_rdy            = '1;
    bus.i_rf_except_in_prog = 1'b0;
    bus.i_rob_flush         = 1'b0;
    if (!q) begin
      case ($urandom_range(0, 3))
        0: bus.i_pu_vld[$urandom_range(0, NUM_PUS-1)] = 1'b1;
        1: bus.i_pu_rdy[$urandom_range(0, NUM_PUS-1)] = 1'b0;
        2: bus.i_rf_except_in_prog = 1'b1;
        default: bus.i_rob_flush = 1'b1;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_prog"}, bus.o_in_prog, 0);
    check({tag, "_flush"},   bus.o_flush,   0);
    check({tag, "_done"},    bus.o_done,    0);
    check({tag, "_src_id"},  bus.o_src_id,  0);
    check({tag, "_cause"},   bus.o_cause,   0);
    check({tag, "_epc"},     bus.o_epc,     0);
    check({tag, "_timeout"}, bus.o_timeout, 0);
    check({tag, "_dropped"}, bus.o_dropped, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_except_vld   = '0;
    bus.i_except_cause = '0;
    bus.i_except_pc    = '0;
    bus.i_ack          = 1'b0;
    set_quiet(1'b1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issues one exception (from IDLE, or with i_ack out of DONE when via_ack),
  // runs the drain with quiet held low for d DRAIN cycles, optionally injects
  // a request at DRAIN cycle inj_j, and leaves the DUT in DONE after ack_dly
  // further cycles without acknowledging.
  task automatic run_txn(input logic [NUM_SRCS-1:0] pattern,
                         input logic [NUM_SRCS*CAUSE_W-1:0] causes,
                         input logic [NUM_SRCS*32-1:0] pcs,
                         input int d, input int inj_j,
                         input logic [NUM_SRCS-1:0] inj_pat,
                         input int ack_dly, input bit via_ack);
    logic [NUM_SRCS-1:0] lsb;
    int                  id;
    int                  len;
    int                  cyc;
    logic                e_to;
    logic                e_drop;
    // reference: lowest set bit wins; drain lasts until quiet or the limit
    lsb = pattern & (~pattern + 1'b1);
    id  = 0;
    for (int s = 0; s < NUM_SRCS; s++) if (lsb == (1 << s)) id = s;
    e_to   = (d >= TMO_LIM);
    len    = e_to ? TMO_LIM : d + 1;
    e_drop = (inj_j != 0) && (inj_j <= len);
    last_id    = SRC_W'(id);
    last_cause = CAUSE_W'(causes >> (id * CAUSE_W));
    last_epc   = 32'(pcs >> (id * 32));
    last_to    = e_to;
    exp_q.push_back({last_id, last_cause, last_epc, e_to, e_drop});

    if (!via_ack) check("in_prog_before_capture", bus.o_in_prog, 0);
    bus.i_except_vld   = pattern;
    bus.i_except_cause = causes;
    bus.i_except_pc    = pcs;
    bus.i_ack          = via_ack;
    tick();
    bus.i_except_vld = '0;
    bus.i_ack        = 1'b0;
    bus.i_except_cause = {NUM_SRCS*CAUSE_W{1'b1}} ^ causes;
    bus.i_except_pc    = ~pcs;
    check("flush_pulse",   bus.o_flush,   1);
    check("in_prog_flush", bus.o_in_prog, 1);
    tick();
    check("flush_single", bus.o_flush, 0);
    cyc = 0;
    for (int j = 1; j <= 40; j++) begin
      set_quiet(j > d);
      bus.i_except_vld = (j == inj_j) ? inj_pat : '0;
      bus.i_ack        = 1'($urandom_range(0, 1));
      tick();
      cyc = j;
      if (bus.o_done) break;
    end
    bus.i_except_vld = '0;
    bus.i_ack        = 1'b0;
    set_quiet(1'b1);
    check("drain_len", cyc, len);
    check("done_set",  bus.o_done, 1);
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      check("done_held", bus.o_done, 1);
    end
  endtask

  task automatic ack_to_idle();
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    check("idle_in_prog", bus.o_in_prog, 0);
    check("idle_done",    bus.o_done,    0);
    check("idle_fields",  {bus.o_src_id, bus.o_cause, bus.o_epc, bus.o_timeout},
          {last_id, last_cause, last_epc, last_to});
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [NUM_SRCS*CAUSE_W-1:0] c;
    logic [NUM_SRCS*32-1:0]      p;
    bit                          in_done;

    do_reset();
    check_all_zero("reset");

    // Sources 1 and 2 together: source 1 wins, quiet drain.
    c = {5'h03, 5'h1f, 5'h02, 5'h07};
    p = {32'h400, 32'h200, 32'h100, 32'h040};
    run_txn(4'b0110, c, p, 0, 0, '0, 0, 1'b0);
    ack_to_idle();

    // Drain never quiet: timeout after TMO_LIM cycles.
    c = {5'h01, 5'h02, 5'h03, 5'h04};
    p = {32'hA000, 32'hB000, 32'hC000, 32'hD000};
    run_txn(4'b0001, c, p, 30, 0, '0, 1, 1'b0);
    ack_to_idle();

    // Request during DRAIN is dropped; fields unchanged; next capture clears.
    c = {5'h0a, 5'h0b, 5'h0c, 5'h0d};
    p = {32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
    run_txn(4'b0100, c, p, 3, 2, 4'b1000, 0, 1'b0);
    // DONE without ack: request is dropped, record untouched.
    bus.i_except_vld = 4'b0001;
    tick();
    bus.i_except_vld = '0;
    check("drop_in_done_flag", bus.o_dropped, 1);
    check("drop_in_done_epc",  bus.o_epc,     last_epc);
    check("drop_in_done_held", bus.o_done,    1);
    // Back-to-back via ack with source 2.
    c = {5'h11, 5'h12, 5'h13, 5'h14};
    p = {32'h0000_0AAA, 32'h0000_0BBB, 32'h0000_0CCC, 32'h0000_0DDD};
    run_txn(4'b0100, c, p, 1, 0, '0, 0, 1'b1);
    ack_to_idle();

    // Async reset in the middle of DRAIN.
    bus.i_except_vld = 4'b1000;
    bus.i_except_pc  = {32'hDEAD_BEEF, 96'h0};
    bus.i_except_cause = {5'h1e, 15'h0};
    tick();
    bus.i_except_vld = '0;
    tick();
    set_quiet(1'b0);
    tick();
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    check("async_rst_state", bus.o_state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    set_quiet(1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_idle", bus.o_in_prog, 0);
    end

    // Randomized traffic.
    in_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [NUM_SRCS-1:0] pat;
      int                  d;
      int                  inj;
      bit                  b2b;
      pat = NUM_SRCS'($urandom_range(1, (1 << NUM_SRCS) - 1));
      for (int s = 0; s < NUM_SRCS; s++) begin
        c[s*CAUSE_W +: CAUSE_W] = CAUSE_W'($urandom);
        p[s*32 +: 32]           = $urandom;
      end
      case ($urandom_range(0, 3))
        0, 1: d = $urandom_range(0, 5);
        2:    d = $urandom_range(10, TMO_LIM - 1);
        default: d = $urandom_range(TMO_LIM, TMO_LIM + 5);
      endcase
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      b2b = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !b2b) ack_to_idle();
      run_txn(pat, c, p, d, inj, NUM_SRCS'($urandom_range(1, 15)),
              $urandom_range(0, 2), b2b);
      in_done = 1'b1;
    end
    ack_to_idle();

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
